// File: rtl/stdp_pkg.sv
// Shared constants, FSM encoding and a small range helper for the STDP weight pipeline.
package stdp_pkg;

  localparam int N_SYN           = 16;
  localparam int IDX_W           = 4;
  localparam int CYC_W           = 5;
  localparam int WEIGHT_W_DEF    = 8;
  localparam int WEIGHT_INIT_DEF = 64;

  // Sweep timeline: reads 0..15, compute 1..16, writes 2..17, counter advance 0..16.
  localparam logic [CYC_W-1:0] CYC_RD_LAST  = 5'd15;
  localparam logic [CYC_W-1:0] CYC_CMP_LAST = 5'd16;
  localparam logic [CYC_W-1:0] CYC_EN_LAST  = 5'd16;
  localparam logic [CYC_W-1:0] CYC_LAST     = 5'd17;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic cyc_in(input logic [CYC_W-1:0] cyc,
                                  input logic [CYC_W-1:0] lo,
                                  input logic [CYC_W-1:0] hi);
    return (cyc >= lo) && (cyc <= hi);
  endfunction

endpackage

// File: rtl/stdp_sat_update.sv
// Single-synapse STDP rule: potentiate on pre+post, depress on pre alone, clamp to range.
module stdp_sat_update
  import stdp_pkg::*;
#(
  parameter int WEIGHT_W = WEIGHT_W_DEF
) (
  input  logic [WEIGHT_W-1:0] w,
  input  logic [WEIGHT_W-1:0] ltp_step,
  input  logic [WEIGHT_W-1:0] ltd_step,
  input  logic                pre,
  input  logic                post,
  output logic [WEIGHT_W-1:0] w_new
);

  logic [WEIGHT_W:0] sum;
  logic [WEIGHT_W:0] diff;

  // The extra top bit is the carry on potentiation and the borrow on depression.
  always_comb begin
    sum   = {1'b0, w} + {1'b0, ltp_step};
    diff  = {1'b0, w} - {1'b0, ltd_step};
    w_new = w;
    if (pre && post) begin
      w_new = sum[WEIGHT_W] ? '1 : sum[WEIGHT_W-1:0];
    end else if (pre) begin
      w_new = diff[WEIGHT_W] ? '0 : diff[WEIGHT_W-1:0];
    end
  end

endmodule

// File: rtl/stdp_weight_pipe.sv
// Three-stage read/compute/write sweep over 16 synaptic weights, paced by an external sweep counter.
//
// state | meaning
// IDLE  | waiting for start; weights readable via rd_addr
// SWEEP | cyc 0..17 pipeline sweep, counter advanced on cyc 0..16
// DONE  | one-cycle completion pulse, start ignored
module stdp_weight_pipe
  import stdp_pkg::*;
#(
  parameter int WEIGHT_W    = WEIGHT_W_DEF,
  parameter int WEIGHT_INIT = WEIGHT_INIT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [N_SYN-1:0]    pre_spike,
  input  logic                post_spike,
  input  logic [WEIGHT_W-1:0] ltp_step,
  input  logic [WEIGHT_W-1:0] ltd_step,
  input  logic [4:0]          main_counter,
  input  logic [IDX_W-1:0]    counter1,
  input  logic [IDX_W-1:0]    counter2,
  output logic                cnt_enable,
  output logic                busy,
  output logic                done,
  input  logic [IDX_W-1:0]    rd_addr,
  output logic [WEIGHT_W-1:0] rd_data
);

  localparam logic [WEIGHT_W-1:0] INIT_W = WEIGHT_W'(WEIGHT_INIT);

  state_t state, state_nxt;
  logic [CYC_W-1:0] cyc;
  logic accept;

  logic [N_SYN-1:0]    pre_lat;
  logic                post_lat;
  logic [WEIGHT_W-1:0] ltp_lat;
  logic [WEIGHT_W-1:0] ltd_lat;

  logic [WEIGHT_W-1:0] weights [N_SYN];
  logic [WEIGHT_W-1:0] rd_w;
  logic [WEIGHT_W-1:0] cmp_w;
  logic [WEIGHT_W-1:0] wr_w;
  logic rd_v, cmp_v, wr_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cyc   <= '0;
    end else begin
      state <= state_nxt;
      cyc   <= (state == SWEEP && cyc != CYC_LAST) ? cyc + 5'd1 : '0;
    end
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    cnt_enable = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SWEEP;
          accept    = 1'b1;
        end
      end
      SWEEP: begin
        busy       = 1'b1;
        cnt_enable = cyc <= CYC_EN_LAST;
        if (cyc == CYC_LAST) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // main_counter[4] only reaches 1 on the final advance, past the last read.
  assign rd_v  = busy && cyc_in(cyc, 5'd0, CYC_RD_LAST) && !main_counter[4];
  assign cmp_v = busy && cyc_in(cyc, 5'd1, CYC_CMP_LAST);
  assign wr_v  = busy && cyc_in(cyc, 5'd2, CYC_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_lat  <= '0;
      post_lat <= 1'b0;
      ltp_lat  <= '0;
      ltd_lat  <= '0;
    end else if (accept) begin
      pre_lat  <= pre_spike;
      post_lat <= post_spike;
      ltp_lat  <= ltp_step;
      ltd_lat  <= ltd_step;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_w <= '0;
    end else if (rd_v) begin
      rd_w <= weights[main_counter[IDX_W-1:0]];
    end
  end

  stdp_sat_update #(.WEIGHT_W(WEIGHT_W)) u_sat_update (
    .w        (rd_w),
    .ltp_step (ltp_lat),
    .ltd_step (ltd_lat),
    .pre      (pre_lat[counter1]),
    .post     (post_lat),
    .w_new    (cmp_w)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_w <= '0;
    end else if (cmp_v) begin
      wr_w <= cmp_w;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_SYN; i++) weights[i] <= INIT_W;
    end else if (wr_v) begin
      weights[counter2] <= wr_w;
    end
  end

  // Write-first: a write landing this edge at rd_addr is what the reader sees.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (wr_v && counter2 == rd_addr) begin
      rd_data <= wr_w;
    end else begin
      rd_data <= weights[rd_addr];
    end
  end

endmodule

// File: tb/tb_stdp_weight_pipe.sv
// Directed plus randomized sweeps of stdp_weight_pipe against a per-synapse arithmetic model.
module tb_stdp_weight_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] pre_spike;
  logic        post_spike;
  logic [7:0]  ltp_step;
  logic [7:0]  ltd_step;
  logic [4:0]  main_counter;
  logic [3:0]  counter1;
  logic [3:0]  counter2;
  logic        cnt_enable;
  logic        busy;
  logic        done;
  logic [3:0]  rd_addr;
  logic [7:0]  rd_data;

  int checks = 0;
  int errors = 0;
  int model_w [16];

  stdp_weight_pipe dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .pre_spike    (pre_spike),
    .post_spike   (post_spike),
    .ltp_step     (ltp_step),
    .ltd_step     (ltd_step),
    .main_counter (main_counter),
    .counter1     (counter1),
    .counter2     (counter2),
    .cnt_enable   (cnt_enable),
    .busy         (busy),
    .done         (done),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data)
  );

  always #5 clk = ~clk;

  // External sweep counter: 0..16 wrapping, with two delayed stage indices.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      main_counter <= 5'd0;
      counter1     <= 4'd0;
      counter2     <= 4'd0;
    end else if (cnt_enable) begin
      main_counter <= (main_counter == 5'd16) ? 5'd0 : main_counter + 5'd1;
      counter1     <= main_counter[3:0];
      counter2     <= counter1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model_w[i] = 64;
  endtask

  task automatic model_sweep(input logic [15:0] p, input logic po, input int lp, input int ld);
    for (int i = 0; i < 16; i++) begin
      if (p[i] && po) model_w[i] = (model_w[i] + lp > 255) ? 255 : model_w[i] + lp;
      else if (p[i])  model_w[i] = (model_w[i] - ld < 0) ? 0 : model_w[i] - ld;
    end
  endtask

  // Streamed readback: each address is checked one cycle after it is presented.
  task automatic chk_weights(input string tag);
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) chk($sformatf("%s[%0d]", tag, i - 1), rd_data, model_w[i - 1]);
      if (i < 16) rd_addr = 4'(i);
      @(negedge clk);
    end
  endtask

  // Called at a negedge; returns at a negedge in IDLE.
  task automatic do_sweep(input logic [15:0] p, input logic po, input int lp, input int ld,
                          input bit pulse_mid);
    int n;
    int en_cnt;
    model_sweep(p, po, lp, ld);
    pre_spike  = p;
    post_spike = po;
    ltp_step   = lp[7:0];
    ltd_step   = ld[7:0];
    rd_addr    = 4'd15;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    pre_spike  = 16'($urandom);
    post_spike = 1'($urandom);
    ltp_step   = 8'($urandom);
    ltd_step   = 8'($urandom);
    chk("busy_after_start", busy, 1);
    n = 1;
    en_cnt = 0;
    while (!done && n < 40) begin
      if (cnt_enable) en_cnt++;
      start = pulse_mid && (n == 5);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("done_cycle", n, 19);
    chk("cnt_enable_cycles", en_cnt, 17);
    chk("busy_low_in_done", busy, 0);
    chk("main_counter_end", main_counter, 0);
    chk("rd_write_first", rd_data, model_w[15]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_done_ignored", busy, 0);
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    pre_spike  = '0;
    post_spike = 1'b0;
    ltp_step   = '0;
    ltd_step   = '0;
    rd_addr    = '0;
    model_reset();

    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt_enable", cnt_enable, 0);
    chk("rst_rd_data", rd_data, 0);
    rst = 1'b0;
    @(negedge clk);
    chk_weights("reset_w");

    do_sweep(16'hFFFF, 1'b1, 10, 0, 1'b0);
    chk_weights("ltp_all_w");

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    do_sweep(16'h0001, 1'b0, 0, 100, 1'b0);
    chk("ltd_sat_first", model_w[0], 0);
    do_sweep(16'h0001, 1'b0, 0, 100, 1'b0);
    chk_weights("ltd_sat_w");

    do_sweep(16'h0020, 1'b1, 186, 0, 1'b0);
    chk_weights("preload_w");
    do_sweep(16'h0020, 1'b1, 10, 0, 1'b1);
    chk_weights("ltp_sat_w");

    pre_spike  = 16'hFFFF;
    post_spike = 1'b1;
    ltp_step   = 8'd50;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort_reached_sweep", busy, 1);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_cnt_enable", cnt_enable, 0);
    chk("abort_main_counter", main_counter, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk_weights("abort_w");
    do_sweep(16'hA5C3, 1'b1, 17, 0, 1'b0);
    chk_weights("post_abort_w");

    for (int k = 0; k < 4; k++) begin
      do_sweep(16'($urandom), 1'($urandom), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 255)), 1'($urandom));
      chk_weights($sformatf("rand%0d_w", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/stdp_weight_pipe.md
STDP_WEIGHT_PIPE -- requirements
Module: stdp_weight_pipe

Interface
REQ-001 Parameter WEIGHT_W, default 8: synaptic weight width in bits, unsigned.
REQ-002 Parameter WEIGHT_INIT, default 64: value every weight takes on reset.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port start, input, 1: single-cycle request to begin one update sweep.
REQ-006 Port pre_spike, input, 16: per-synapse presynaptic spike flags, sampled at sweep start.
REQ-007 Port post_spike, input, 1: postsynaptic spike flag, sampled at sweep start.
REQ-008 Port ltp_step, input, WEIGHT_W: potentiation increment.
REQ-009 Port ltd_step, input, WEIGHT_W: depression decrement.
REQ-010 Port main_counter, input, 5: read-stage index, 0-16, from the sweep counter.
REQ-011 Port counter1, input, 4: compute-stage index from the sweep counter.
REQ-012 Port counter2, input, 4: write-stage index from the sweep counter.
REQ-013 Port cnt_enable, output, 1: advance enable driven to the sweep counter.
REQ-014 Port busy, output, 1: high from the cycle after accepted start through the final write.
REQ-015 Port done, output, 1: one-cycle pulse after the final write.
REQ-016 Port rd_addr, input, 4: external weight readback address.
REQ-017 Port rd_data, output, WEIGHT_W: weight at rd_addr, registered, one-cycle latency.

Function
REQ-018 The FSM SHALL have states IDLE, SWEEP and DONE; IDLE to SWEEP on start, SWEEP to DONE after sweep cycle 17, DONE to IDLE unconditionally.
REQ-019 start SHALL be ignored unless the FSM is in IDLE; on acceptance, pre_spike and post_spike SHALL be latched and step inputs SHALL be latched.
REQ-020 An internal 5-bit cycle counter cyc SHALL run 0..17 in SWEEP; cnt_enable SHALL be high for cyc 0..16 (17 cycles) and low otherwise, leaving the sweep counter at main_counter=0.
REQ-021 Stage valids: read when cyc 0..15 (address main_counter[3:0]); compute when cyc 1..16 (index counter1); write when cyc 2..17 (index counter2, =15 at cyc 17).
REQ-022 Compute rule per synapse i: pre and post latched high gives w+ltp_step saturating at 2^WEIGHT_W-1; pre only gives w-ltd_step saturating at 0; otherwise w unchanged.
REQ-023 Saturation SHALL use a WEIGHT_W+1-bit intermediate; no wrap-around.
REQ-024 Read, compute and write indices are always distinct in a cycle, so no forwarding is required; each weight is read exactly once and written exactly once per sweep.
REQ-025 done SHALL assert in the DONE state only, for exactly one cycle; busy SHALL be low in that cycle.
REQ-026 start asserted in the DONE cycle SHALL be ignored; start in IDLE the cycle after DONE SHALL be accepted.
REQ-027 rd_data SHALL reflect the register file contents including a write landing in the same cycle as the read sample (write-first).

Reset
REQ-028 On rst: FSM to IDLE, cyc=0, cnt_enable=0, busy=0, done=0, rd_data=0, all 16 weights=WEIGHT_INIT, latched flags and steps=0.
REQ-029 rst mid-sweep SHALL abort immediately with no partial write surviving; the sweep counter is reset by the same rst.

Structure
REQ-030 Package stdp_pkg SHALL hold N_SYN=16, the FSM state enum, and the default WEIGHT_W and WEIGHT_INIT constants.
REQ-031 Sub-module stdp_sat_update SHALL implement REQ-022/023 combinationally; the top instantiates it once in the compute stage.

Verification
REQ-032 Reset, then rd_addr sweep 0..15 -> rd_data=64 for every index, one cycle late.
REQ-033 pre_spike=16'hFFFF, post=1, ltp=10, start -> cnt_enable high 17 cycles, done at cycle 19 after start, all weights=74, main_counter ends at 0.
REQ-034 pre_spike=16'h0001, post=0, ltd=100, two sweeps -> w[0]=0 (saturates, 64 then 0), w[1..15]=64.
REQ-035 Preload w[5]=250 via sweeps, then ltp=10 -> w[5]=255; start pulsed during busy -> no extra sweep.
REQ-036 rst asserted at cyc 9 -> busy=0, cnt_enable=0, all weights=64, next start runs a full correct sweep.
